// File: rtl/nn_layer_sequencer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nn_layer_sequencer_pkg
// Purpose  : Shared state encoding and layer descriptor layout.
// Revision : 1.0
// ============================================================================
package nn_layer_sequencer_pkg;

    localparam int C_DESC_W   = 32;
    localparam int C_FIELD_W  = 8;
    localparam int C_NK_LSB   = 24;
    localparam int C_WB_LSB   = 16;
    localparam int C_NRB_LSB  = 8;
    localparam int C_NWB_LSB  = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    typedef struct packed {
        logic [C_FIELD_W-1:0] nk;
        logic [C_FIELD_W-1:0] w_base;
        logic [C_FIELD_W-1:0] nr_base;
        logic [C_FIELD_W-1:0] nw_base;
    } desc_t;

    function automatic desc_t desc_unpack(input logic [C_DESC_W-1:0] raw);
        desc_t d;
        d.nk      = raw[C_NK_LSB  +: C_FIELD_W];
        d.w_base  = raw[C_WB_LSB  +: C_FIELD_W];
        d.nr_base = raw[C_NRB_LSB +: C_FIELD_W];
        d.nw_base = raw[C_NWB_LSB +: C_FIELD_W];
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/nn_layer_sequencer_delay.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nn_seq_delay_line
// Purpose  : DEPTH-cycle single-bit shift register with synchronous flush.
// Revision : 1.0
// ============================================================================
module nn_seq_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [DEPTH-1:0] r_sh;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (rst) r_sh <= '0;
                else     r_sh <= i_d;
            end
        end else begin : g_shift
            always_ff @(posedge clk) begin
                if (rst) r_sh <= '0;
                else     r_sh <= {r_sh[DEPTH-2:0], i_d};
            end
        end
    endgenerate

    assign o_q = r_sh[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/nn_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nn_layer_sequencer
// Purpose  : Steps a descriptor-driven fully-connected network through the
//            shared MAC and address generator, one layer at a time.
// Revision : 1.0
// ============================================================================
module nn_layer_sequencer
    import nn_layer_sequencer_pkg::*;
#(
    parameter int MAX_LAYERS = 8,
    parameter int LIDX_W     = 3,
    parameter int MAC_LAT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [LIDX_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_data,
    input  logic              start,
    input  logic [LIDX_W:0]   num_layers,
    input  logic [7:0]        num_inputs,
    input  logic              agen_finished,
    input  logic              agen_neuron_finished,
    output logic              agen_read,
    output logic [7:0]        agen_nk,
    output logic [7:0]        agen_w_base,
    output logic [7:0]        agen_nr_base,
    output logic [7:0]        agen_nw_base,
    output logic              mac_en,
    output logic              mac_clear,
    output logic              mac_last,
    output logic              nw_we,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [LIDX_W-1:0] layer_idx
);

    localparam int DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    state_t              r_state;
    desc_t               r_table [MAX_LAYERS];
    logic [LIDX_W:0]     r_num_layers;
    logic [7:0]          r_num_inputs;
    logic [DRAIN_W-1:0]  r_drain_cnt;

    logic [LIDX_W-1:0]   w_next_idx;
    logic [LIDX_W-1:0]   w_load_idx;
    desc_t               w_load_desc;
    logic                w_cfg_bad;
    logic                w_last_layer;

    assign w_next_idx   = r_layer_idx_plus1(layer_idx);
    assign w_load_idx   = (r_state == S_DRAIN) ? w_next_idx : layer_idx;
    assign w_load_desc  = r_table[w_load_idx];
    assign w_cfg_bad    = (r_num_inputs == 8'd0) || (r_num_layers == '0) ||
                          (r_num_layers > (LIDX_W+1)'(MAX_LAYERS));
    assign w_last_layer = ({1'b0, layer_idx} == (r_num_layers - (LIDX_W+1)'(1)));

    // Combinational so the MAC sees "last" alongside the final operand pair.
    assign mac_last = (r_state == S_RUN) && agen_neuron_finished;

    function automatic logic [LIDX_W-1:0] r_layer_idx_plus1(input logic [LIDX_W-1:0] idx);
        return idx + LIDX_W'(1);
    endfunction

    // Table is writable only while idle; contents survive reset.
    always_ff @(posedge clk) begin
        if (cfg_we && (r_state == S_IDLE))
            r_table[cfg_addr] <= desc_unpack(cfg_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_num_layers <= '0;
            r_num_inputs <= '0;
            r_drain_cnt  <= '0;
            agen_read    <= 1'b0;
            agen_nk      <= '0;
            agen_w_base  <= '0;
            agen_nr_base <= '0;
            agen_nw_base <= '0;
            mac_en       <= 1'b0;
            mac_clear    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            layer_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_layers <= num_layers;
                        r_num_inputs <= num_inputs;
                        err          <= 1'b0;
                        busy         <= 1'b1;
                        layer_idx    <= '0;
                        // Priming read: the generator shifts this Nk into
                        // its input count when layer 0 is loaded.
                        agen_read    <= 1'b1;
                        agen_nk      <= num_inputs;
                        agen_w_base  <= '0;
                        agen_nr_base <= '0;
                        agen_nw_base <= '0;
                        r_state      <= S_PRIME;
                    end
                end
                S_PRIME: begin
                    if (w_cfg_bad) begin
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        agen_read <= 1'b0;
                        agen_nk   <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        agen_read    <= 1'b1;
                        agen_nk      <= w_load_desc.nk;
                        agen_w_base  <= w_load_desc.w_base;
                        agen_nr_base <= w_load_desc.nr_base;
                        agen_nw_base <= w_load_desc.nw_base;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    agen_read <= 1'b0;
                    if (agen_nk == 8'd0) begin
                        err     <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        mac_en    <= 1'b1;
                        mac_clear <= 1'b1;
                        r_state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (agen_finished) begin
                        mac_en      <= 1'b0;
                        mac_clear   <= 1'b0;
                        r_drain_cnt <= '0;
                        r_state     <= S_DRAIN;
                    end else begin
                        mac_clear <= agen_neuron_finished;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_W'(MAC_LAT - 1)) begin
                        if (w_last_layer) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            layer_idx    <= w_next_idx;
                            agen_read    <= 1'b1;
                            agen_nk      <= w_load_desc.nk;
                            agen_w_base  <= w_load_desc.w_base;
                            agen_nr_base <= w_load_desc.nr_base;
                            agen_nw_base <= w_load_desc.nw_base;
                            r_state      <= S_LOAD;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    nn_seq_delay_line #(
        .DEPTH (MAC_LAT)
    ) u_nw_we_dly (
        .clk (clk),
        .rst (reset),
        .i_d (mac_last),
        .o_q (nw_we)
    );

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_nn_layer_sequencer
// Purpose  : Directed self-checking bench for nn_layer_sequencer.
// Revision : 1.0
// ============================================================================
module tb_nn_layer_sequencer;

    localparam int MAX_LAYERS = 8;
    localparam int LIDX_W     = 3;
    localparam int MAC_LAT    = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              cfg_we;
    logic [LIDX_W-1:0] cfg_addr;
    logic [31:0]       cfg_data;
    logic              start;
    logic [LIDX_W:0]   num_layers;
    logic [7:0]        num_inputs;
    logic              agen_finished;
    logic              agen_neuron_finished;
    logic              agen_read;
    logic [7:0]        agen_nk;
    logic [7:0]        agen_w_base;
    logic [7:0]        agen_nr_base;
    logic [7:0]        agen_nw_base;
    logic              mac_en;
    logic              mac_clear;
    logic              mac_last;
    logic              nw_we;
    logic              busy;
    logic              done;
    logic              err;
    logic [LIDX_W-1:0] layer_idx;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    nn_layer_sequencer #(
        .MAX_LAYERS (MAX_LAYERS),
        .LIDX_W     (LIDX_W),
        .MAC_LAT    (MAC_LAT)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .cfg_we               (cfg_we),
        .cfg_addr             (cfg_addr),
        .cfg_data             (cfg_data),
        .start                (start),
        .num_layers           (num_layers),
        .num_inputs           (num_inputs),
        .agen_finished        (agen_finished),
        .agen_neuron_finished (agen_neuron_finished),
        .agen_read            (agen_read),
        .agen_nk              (agen_nk),
        .agen_w_base          (agen_w_base),
        .agen_nr_base         (agen_nr_base),
        .agen_nw_base         (agen_nw_base),
        .mac_en               (mac_en),
        .mac_clear            (mac_clear),
        .mac_last             (mac_last),
        .nw_we                (nw_we),
        .busy                 (busy),
        .done                 (done),
        .err                  (err),
        .layer_idx            (layer_idx)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [LIDX_W-1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic do_start(input int nl, input int ni);
        start = 1'b1; num_layers = (LIDX_W+1)'(nl); num_inputs = 8'(ni);
        tick();
        start = 1'b0;
    endtask

    task automatic chk_prime(input int ni);
        chk("prime_read", agen_read, 1);
        chk("prime_nk", agen_nk, ni);
        chk("prime_wbase", agen_w_base, 0);
        chk("prime_nwbase", agen_nw_base, 0);
        chk("prime_busy", busy, 1);
        chk("prime_mac_en", mac_en, 0);
    endtask

    task automatic chk_load(input int idx, input int nk, input int wb, input int nrb, input int nwb);
        chk("load_read", agen_read, 1);
        chk("load_nk", agen_nk, nk);
        chk("load_wbase", agen_w_base, wb);
        chk("load_nrbase", agen_nr_base, nrb);
        chk("load_nwbase", agen_nw_base, nwb);
        chk("load_layer_idx", layer_idx, idx);
        chk("load_busy", busy, 1);
    endtask

    // Plays the address generator for one layer, then checks the drain window.
    task automatic run_layer(input int nin, input int nk);
        int n;
        n = nin * nk;
        for (int r = 1; r <= n; r++) begin
            agen_neuron_finished = (r % nin == 0);
            agen_finished        = (r == n);
            #1;
            chk("run_mac_en", mac_en, 1);
            chk("run_mac_clear", mac_clear, ((r - 1) % nin == 0));
            chk("run_mac_last", mac_last, (r % nin == 0));
            chk("run_nw_we", nw_we, (r > MAC_LAT) && ((r - MAC_LAT) % nin == 0));
            chk("run_read", agen_read, 0);
            chk("run_done", done, 0);
            tick();
        end
        agen_neuron_finished = 1'b0;
        agen_finished        = 1'b0;
        for (int d = 1; d <= MAC_LAT; d++) begin
            chk("drain_mac_en", mac_en, 0);
            chk("drain_mac_last", mac_last, 0);
            chk("drain_nw_we", nw_we, ((n + d - MAC_LAT) % nin == 0));
            chk("drain_busy", busy, 1);
            chk("drain_done", done, 0);
            tick();
        end
    endtask

    task automatic chk_done_then_idle();
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        tick();
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_err", err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        start = 1'b0; num_layers = '0; num_inputs = '0;
        agen_finished = 1'b0; agen_neuron_finished = 1'b0;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_read", agen_read, 0);
        chk("rst_nk", agen_nk, 0);
        chk("rst_mac_en", mac_en, 0);
        chk("rst_mac_clear", mac_clear, 0);
        chk("rst_nw_we", nw_we, 0);
        chk("rst_layer_idx", layer_idx, 0);
        reset = 1'b0;
        tick();

        // One layer: 2 inputs, 3 neurons.
        cfg_write(3'd0, {8'd3, 8'h10, 8'h20, 8'h30});
        do_start(1, 2);
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h10, 'h20, 'h30);
        tick();
        run_layer(2, 3);
        chk_done_then_idle();

        // Two layers: 2 -> 3 -> 1, second load carries nk=1 without priming.
        cfg_write(3'd1, {8'd1, 8'h11, 8'h22, 8'h33});
        do_start(2, 2);
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h10, 'h20, 'h30);
        tick();
        run_layer(2, 3);
        chk_load(1, 1, 'h11, 'h22, 'h33);
        tick();
        run_layer(3, 1);
        chk_done_then_idle();
        tick();
        chk("two_layer_single_done", done, 0);

        // nk=0 at layer 1 raises err after that load.
        cfg_write(3'd1, {8'd0, 8'h77, 8'h88, 8'h99});
        do_start(2, 2);
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h10, 'h20, 'h30);
        tick();
        run_layer(2, 3);
        chk_load(1, 0, 'h77, 'h88, 'h99);
        chk("nk0_err_pending", err, 0);
        tick();
        chk("nk0_err", err, 1);
        chk("nk0_busy", busy, 0);
        chk("nk0_done", done, 0);
        chk("nk0_mac_en", mac_en, 0);
        tick();
        chk("nk0_err_sticky", err, 1);
        chk("nk0_no_done", done, 0);
        do_start(1, 2);
        chk("restart_clears_err", err, 0);
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h10, 'h20, 'h30);
        tick();
        run_layer(2, 3);
        chk_done_then_idle();

        // Bad run parameters are rejected from PRIME.
        do_start(1, 0);
        chk_prime(0);
        tick();
        chk("ni0_err", err, 1);
        chk("ni0_busy", busy, 0);
        chk("ni0_read", agen_read, 0);
        tick();
        chk("ni0_no_run", mac_en, 0);
        chk("ni0_no_done", done, 0);
        do_start(0, 2);
        chk("nl0_err_cleared", err, 0);
        chk_prime(2);
        tick();
        chk("nl0_err", err, 1);
        chk("nl0_busy", busy, 0);
        tick();
        chk("nl0_no_run", mac_en, 0);
        do_start(9, 2);
        chk_prime(2);
        tick();
        chk("nl9_err", err, 1);
        chk("nl9_busy", busy, 0);
        chk("nl9_no_load", agen_read, 0);

        // Reset in the middle of RUN, one cycle before an nw_we is due.
        do_start(1, 2);
        tick();
        tick();
        chk("mid_run_mac_en", mac_en, 1);
        tick();
        agen_neuron_finished = 1'b1;
        #1;
        chk("mid_run_last", mac_last, 1);
        tick();
        agen_neuron_finished = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_mac_en", mac_en, 0);
        chk("mid_rst_nw_we", nw_we, 0);
        chk("mid_rst_mac_clear", mac_clear, 0);
        chk("mid_rst_mac_last", mac_last, 0);
        chk("mid_rst_done", done, 0);
        tick();
        chk("mid_rst_nw_we_2", nw_we, 0);
        chk("mid_rst_idle", busy, 0);

        // start and cfg_we during a run are ignored.
        do_start(1, 2);
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h10, 'h20, 'h30);
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = {8'd5, 8'h99, 8'h99, 8'h99};
        start = 1'b1; num_layers = 4'd3; num_inputs = 8'd7;
        tick();
        cfg_we = 1'b0; start = 1'b0;
        run_layer(2, 3);
        chk_done_then_idle();
        do_start(1, 2);
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h10, 'h20, 'h30);
        tick();
        run_layer(2, 3);
        chk_done_then_idle();

        // start together with cfg_we in IDLE: write lands, start accepted.
        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = {8'd3, 8'h44, 8'h55, 8'h66};
        do_start(1, 2);
        cfg_we = 1'b0;
        chk_prime(2);
        tick();
        chk_load(0, 3, 'h44, 'h55, 'h66);
        tick();
        run_layer(2, 3);
        chk_done_then_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
